sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between N requesters, e.g. ADC capture writer, display reader and debug port.
- Round-robin arbitration; the grant is held for up to BURST back-to-back accesses from the same requester.
- Read responses are routed back to their issuer through an in-order tag FIFO.
- Sits between the capture/display datapaths and the SDRAM controller driving DRAM_* pins.

Parameters:
- N, 4, number of requesters (2..8)
- AW, 24, word address width
- DW, 16, data width (matches DRAM_DQ)
- BURST, 8, maximum consecutive accepted commands per grant (1..255)
- TAG_DEPTH, 8, outstanding-read tag FIFO depth (power of 2)

Ports:
- clk  in  1  system clock (same clock as the SDRAM controller)
- n_reset  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester command valid
- req_we  in  N  per-requester 1=write, 0=read
- req_addr  in  N*AW  per-requester address, requester i at [i*AW +: AW]
- req_data  in  N*DW  per-requester write data
- req_ready  out  N  command accepted this cycle (valid&ready)
- rsp_valid  out  N  read data valid for requester i (one-hot)
- rsp_data  out  DW  read data, shared by all requesters
- mem_valid  out  1  command to controller
- mem_we  out  1  command write flag
- mem_addr  out  AW  command address
- mem_data  out  DW  command write data
- mem_ready  in  1  controller accepts command
- mem_rsp_valid  in  1  controller read data valid (in issue order)
- mem_rsp_data  in  DW  controller read data
- err_orphan  out  1  sticky: mem_rsp_valid arrived with tag FIFO empty

Behaviour:
- Reset (async, n_reset low): state IDLE; ptr=0; burst count=0; tag FIFO empty; all outputs 0 (req_ready, rsp_valid, rsp_data, mem_*, err_orphan). Reset mid-transfer discards in-flight tags; subsequent mem_rsp_valid sets err_orphan.
- FSM IDLE: scan req_valid starting at index ptr, wrapping mod N; first valid index g becomes the owner; go to GRANT next cycle. No valid requester: stay IDLE.
- FSM GRANT: mem_valid/we/addr/data are a combinational mux of owner g's request.
  - mem_valid = req_valid[g] & ~(read & tag_full).
  - req_ready[g] = mem_valid & mem_ready; all other req_ready bits are 0.
- Each accepted command increments the burst count.
- Leave GRANT for IDLE, with ptr=(g+1) mod N, when any of these holds:
  - count reaches BURST on an accept;
  - req_valid[g] is low;
  - a read is blocked by a full tag FIFO.
- Count clears on leaving GRANT. Arbitration costs one idle cycle per grant change.
- Tag FIFO: push g on every accepted read.
  - On mem_rsp_valid: pop head h; next cycle rsp_valid[h]=1 and rsp_data=mem_rsp_data (1-cycle registered latency). rsp_valid is otherwise 0.
  - rsp_data holds its last value.
- Simultaneous push and pop: both occur; occupancy is unchanged.
  - Full and pop in the same cycle: a read is still blocked this cycle (full is evaluated before the pop).
- Pop with FIFO empty: no rsp_valid, err_orphan set until reset.
- Writes are never blocked by the tag FIFO.
- Pointer and count arithmetic wraps mod N and mod 256 respectively.

Optional Feature:
- Macro SDRAM_ARB_PRIO0_EN.
- Defined: requester 0, the ADC capture writer, has strict priority.
  - In IDLE it is chosen whenever req_valid[0] is set, regardless of ptr.
  - While it owns the grant, the BURST limit does not apply; the grant holds until req_valid[0] drops.
  - Other requesters leave GRANT at the BURST limit as normal, so requester 0 is re-granted within BURST+1 cycles.
- Not defined: pure round-robin for all requesters as described above.

Test Plan:
- Single requester 1 issues 3 writes (addr 0x10..0x12, data 0xA0..0xA2), mem_ready=1 -> grant after 1 IDLE cycle, mem_addr 0x10,0x11,0x12 on consecutive cycles, req_ready[1] high 3 cycles, then IDLE with ptr=2.
- All 4 requesters continuously valid, BURST=8 -> grants 0,1,2,3,0 in order, each exactly 8 accepts, 1 idle cycle between grants.
- Requester 2 issues 10 reads with controller response delayed 20 cycles, TAG_DEPTH=8 -> 8 accepted, then grant released; after responses, rsp_valid[2] pulses 8 times with data matching controller order, 1 cycle after each mem_rsp_valid.
- Interleaved reads from requesters 1 and 3, controller returns 0x1111 then 0x3333 -> rsp_valid[1] with 0x1111, then rsp_valid[3] with 0x3333.
- mem_rsp_valid with no outstanding reads -> err_orphan=1, no rsp_valid; n_reset pulse clears it to 0.
- With SDRAM_ARB_PRIO0_EN, requesters 0 and 2 valid, requester 0 issues 20 writes -> all 20 accepted in one grant; requester 2 is then served.
- With SDRAM_ARB_PRIO0_EN, requester 0 raises req_valid during requester 2's burst -> requester 0 is granted immediately after that burst ends.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port among N requesters,
// with an in-order tag FIFO routing read data back. Define SDRAM_ARB_PRIO0_EN for requester-0 strict priority.

module sdram_arb_lane #(
    parameter int TW  = 2,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          in_grant,
    input  logic [TW-1:0] owner,
    input  logic          accept,
    input  logic          rsp_fire,
    input  logic [TW-1:0] rsp_tag,
    output logic          req_ready,
    output logic          rsp_valid
);
    logic mine;

    assign mine      = in_grant && (owner == TW'(IDX));
    assign req_ready = mine & accept;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) rsp_valid <= 1'b0;
        else          rsp_valid <= rsp_fire && (rsp_tag == TW'(IDX));
    end
endmodule

module sdram_arbiter #(
    parameter int N         = 4,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int BURST     = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    input  logic            mem_ready,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data,
    output logic            err_orphan
);
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [TW-1:0] ptr, owner, pick, next_ptr;
    logic          pick_vld;
    logic [7:0]    cnt, cnt_nxt;
    logic [TW:0]   sum;

    logic          o_valid, o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          in_grant, tag_full, rd_block, accept, push, pop, burst_hit, leave;

    logic [TW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] tag_cnt;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (TW+1)'(k);
            if (sum >= (TW+1)'(N)) sum = sum - (TW+1)'(N);
            if (!pick_vld && req_valid[sum]) begin
                pick_vld = 1'b1;
                pick     = sum[TW-1:0];
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (req_valid[0]) begin
            pick_vld = 1'b1;
            pick     = '0;
        end
`endif
    end

    assign o_valid  = req_valid[owner];
    assign o_we     = req_we[owner];
    assign o_addr   = req_addr[owner*AW +: AW];
    assign o_data   = req_data[owner*DW +: DW];

    assign in_grant = (state == GRANT);
    // Occupancy is the registered count, so a same-cycle pop does not unblock a read.
    assign tag_full = (tag_cnt == CW'(TAG_DEPTH));
    assign rd_block = in_grant & o_valid & ~o_we & tag_full;

    assign mem_valid = in_grant & o_valid & ~rd_block;
    assign mem_we    = in_grant & o_we;
    assign mem_addr  = in_grant ? o_addr : '0;
    assign mem_data  = in_grant ? o_data : '0;

    assign accept  = mem_valid & mem_ready;
    assign push    = accept & ~o_we;
    assign pop     = mem_rsp_valid && (tag_cnt != '0);
    assign cnt_nxt = cnt + 8'd1;

`ifdef SDRAM_ARB_PRIO0_EN
    assign burst_hit = accept && (cnt_nxt == 8'(BURST)) && (owner != '0);
`else
    assign burst_hit = accept && (cnt_nxt == 8'(BURST));
`endif
    assign leave    = burst_hit | ~o_valid | rd_block;
    assign next_ptr = (owner == TW'(N-1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (leave) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wp] <= owner;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wp         <= '0;
            rp         <= '0;
            tag_cnt    <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wp <= (wp == PW'(TAG_DEPTH-1)) ? '0 : wp + 1'b1;
            if (pop)  rp <= (rp == PW'(TAG_DEPTH-1)) ? '0 : rp + 1'b1;
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            if (pop) rsp_data <= mem_rsp_data;
            if (mem_rsp_valid && (tag_cnt == '0)) err_orphan <= 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        sdram_arb_lane #(.TW(TW), .IDX(i)) u_lane (
            .clk      (clk),
            .n_reset  (n_reset),
            .in_grant (in_grant),
            .owner    (owner),
            .accept   (accept),
            .rsp_fire (pop),
            .rsp_tag  (tag_mem[rp]),
            .req_ready(req_ready[i]),
            .rsp_valid(rsp_valid[i])
        );
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected command order from grant segments, read routing via a memory model.
module tb_sdram_arbiter;
    localparam int N = 4, AW = 24, DW = 16, BURST = 8, TAG_DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            n_reset;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   rsp_data, mem_data, mem_rsp_data;
    logic            mem_valid, mem_we, mem_ready, mem_rsp_valid, err_orphan;
    logic [AW-1:0]   mem_addr;

    sdram_arbiter #(.N(N), .AW(AW), .DW(DW), .BURST(BURST), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_valid(mem_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .err_orphan(err_orphan)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int id; cmd_t c; int gap; } exp_t;
    typedef struct { int id; int due; } rd_t;
    typedef struct { int id; logic [DW-1:0] data; int cyc; } rsp_t;

    cmd_t          rq[N][$];
    cmd_t          sh[N][$];
    int            start[N];
    exp_t          exp_q[$];
    rd_t           rd_q[$];
    rsp_t          exp_rsp[$];
    logic [DW-1:0] data_ovr[$];

    int cyc = 0, nchk = 0, nerr = 0, out_cnt = 0, peak = 0, last_cyc = 0, last_due = 0;
    int dly_min = 1, dly_max = 1;
    bit rdy_rand = 0, orphan_pulse = 0;
    logic [N-1:0] acc_flag = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester sources and memory-controller model
    always @(posedge clk) begin
        cmd_t t;
        rd_t  r;
        rsp_t s;
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i] && rq[i].size() > 0) t = rq[i].pop_front();
            acc_flag[i] = 1'b0;
            if (n_reset && rq[i].size() > 0 && cyc >= start[i]) begin
                req_valid[i] = 1'b1;
                req_we[i] = rq[i][0].we;
                req_addr[i*AW +: AW] = rq[i][0].addr;
                req_data[i*DW +: DW] = rq[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        mem_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (orphan_pulse) begin
            orphan_pulse = 0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data = DW'($urandom);
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            s.id = r.id;
            s.data = (data_ovr.size() > 0) ? data_ovr.pop_front() : DW'($urandom);
            s.cyc = cyc;
            mem_rsp_valid = 1'b1;
            mem_rsp_data = s.data;
            exp_rsp.push_back(s);
        end else begin
            mem_rsp_valid = 1'b0;
        end
    end

    // Monitor: compare every accepted command and every response against the queues
    exp_t          me;
    rsp_t          mr;
    rd_t           nr;
    logic [N-1:0]  oh;
    always @(negedge clk) begin
        if (n_reset) begin
            for (int i = 0; i < N; i++) acc_flag[i] = req_ready[i];
            if (mem_valid && !mem_we) chk("tag_full_block", 64'(out_cnt >= TAG_DEPTH), 0);
            if (mem_valid && mem_ready) begin
                chk("cmd_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    oh = '0;
                    oh[me.id] = 1'b1;
                    chk("cmd_owner", 64'(req_ready), 64'(oh));
                    chk("cmd_we", 64'(mem_we), 64'(me.c.we));
                    chk("cmd_addr", 64'(mem_addr), 64'(me.c.addr));
                    chk("cmd_data", 64'(mem_data), 64'(me.c.data));
                    if (me.gap > 0) chk("cmd_gap", 64'(cyc - last_cyc), 64'(me.gap));
                    last_cyc = cyc;
                    if (!me.c.we) begin
                        nr.id = me.id;
                        nr.due = cyc + int'($urandom_range(dly_min, dly_max));
                        if (nr.due <= last_due) nr.due = last_due + 1;
                        last_due = nr.due;
                        rd_q.push_back(nr);
                        out_cnt++;
                    end
                end
            end else begin
                chk("ready_idle", 64'(req_ready), 0);
            end
            if (mem_rsp_valid && out_cnt > 0) out_cnt--;
            if (out_cnt > peak) peak = out_cnt;
            if (rsp_valid != '0) begin
                chk("rsp_expected", 64'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    mr = exp_rsp.pop_front();
                    oh = '0;
                    oh[mr.id] = 1'b1;
                    chk("rsp_owner", 64'(rsp_valid), 64'(oh));
                    chk("rsp_data", 64'(rsp_data), 64'(mr.data));
                    chk("rsp_latency", 64'(cyc - mr.cyc), 1);
                end
            end
        end
    end

    // kind: 0 write, 1 read, 2 mixed; base < 0 means random
    task automatic load(input int id, input int n, input int kind, input int abase, input int dbase, input int off);
        cmd_t c;
        for (int k = 0; k < n; k++) begin
            c.we   = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            c.addr = (abase < 0) ? AW'($urandom) : AW'(abase + k);
            c.data = (dbase < 0) ? DW'($urandom) : DW'(dbase + k);
            rq[id].push_back(c);
            sh[id].push_back(c);
        end
        start[id] = cyc + 1 + off;
        last_cyc = cyc + 1;
    endtask

    // One grant segment: n commands from id; g1 = cycles since previous accept for the first, gr for the rest
    task automatic seg(input int id, input int n, input int g1, input int gr);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id = id;
            e.c = sh[id].pop_front();
            e.gap = (k == 0) ? g1 : gr;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit quiet();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
        return (rd_q.size() == 0) && (exp_rsp.size() == 0) && !mem_rsp_valid;
    endfunction

    task automatic drain(input int budget);
        int k = 0;
        while (k < budget && !quiet()) begin
            @(posedge clk); #3;
            k++;
        end
        chk("drain_timeout", 64'(k < budget), 1);
        repeat (4) @(posedge clk);
        #3;
        chk("exp_left", 64'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        n_reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            sh[i].delete();
        end
        exp_q.delete(); rd_q.delete(); exp_rsp.delete(); data_ovr.delete();
        out_cnt = 0; last_due = 0; acc_flag = '0; orphan_pulse = 0;
        repeat (2) @(posedge clk);
        #2 n_reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_mem_valid", 64'(mem_valid), 0);
        chk("rst_mem_cmd", 64'({mem_we, mem_addr, mem_data}), 0);
        chk("rst_err_orphan", 64'(err_orphan), 0);
    endtask

    initial begin
        int k;
        n_reset = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
        mem_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        for (int i = 0; i < N; i++) start[i] = 0;
        do_reset();

        // Single requester, 3 writes, then ptr moves to 2
        load(1, 3, 0, 'h10, 'hA0, 0);
        seg(1, 3, 1, 1);
        drain(100);
        load(0, 1, 0, -1, -1, 0);
        load(2, 1, 0, -1, -1, 0);
`ifdef SDRAM_ARB_PRIO0_EN
        seg(0, 1, 1, 0); seg(2, 1, 3, 0);
`else
        seg(2, 1, 1, 0); seg(0, 1, 3, 0);
`endif
        drain(100);

        // All requesters continuously valid
        do_reset();
        load(0, 16, 0, -1, -1, 0);
        for (int i = 1; i < N; i++) load(i, 8, 0, -1, -1, 0);
`ifdef SDRAM_ARB_PRIO0_EN
        seg(0, 16, 1, 1); seg(1, 8, 3, 1); seg(2, 8, 2, 1); seg(3, 8, 2, 1);
`else
        seg(0, 8, 1, 1); seg(1, 8, 2, 1); seg(2, 8, 2, 1); seg(3, 8, 2, 1); seg(0, 8, 2, 1);
`endif
        drain(300);

        // Tag FIFO fills with slow responses
        do_reset();
        dly_min = 20; dly_max = 20; peak = 0;
        load(2, 10, 1, -1, -1, 0);
        seg(2, 10, 0, 0);
        drain(500);
        chk("tag_peak", 64'(peak), TAG_DEPTH);

        // Interleaved reads routed back to issuers
        do_reset();
        dly_min = 3; dly_max = 3;
        data_ovr.push_back(16'h1111);
        data_ovr.push_back(16'h3333);
        load(1, 1, 1, 'h100, -1, 0);
        load(3, 1, 1, 'h300, -1, 0);
        seg(1, 1, 1, 0); seg(3, 1, 3, 0);
        drain(100);

        // Randomized single-requester traffic with stalls and variable read latency
        rdy_rand = 1; dly_min = 1; dly_max = 30;
        for (int r = 0; r < 4; r++) begin
            k = int'($urandom_range(0, N-1));
            load(k, 40, 2, -1, -1, 0);
            seg(k, 40, 0, 0);
            drain(2000);
        end
        rdy_rand = 0;

        // Orphan response
        chk("orphan_before", 64'(err_orphan), 0);
        @(posedge clk); #2 orphan_pulse = 1;
        repeat (3) @(posedge clk);
        #3;
        chk("orphan_set", 64'(err_orphan), 1);
        chk("orphan_no_rsp", 64'(rsp_valid), 0);
        do_reset();

        // Reset with reads in flight discards their tags
        dly_min = 40; dly_max = 40;
        load(2, 3, 1, -1, -1, 0);
        seg(2, 3, 0, 0);
        k = 0;
        while (k < 100 && out_cnt < 3) begin
            @(posedge clk); #3;
            k++;
        end
        chk("inflight_wait", 64'(k < 100), 1);
        do_reset();
        @(posedge clk); #2 orphan_pulse = 1;
        repeat (3) @(posedge clk);
        #3;
        chk("orphan_after_rst", 64'(err_orphan), 1);
        do_reset();

`ifdef SDRAM_ARB_PRIO0_EN
        dly_min = 1; dly_max = 1;
        load(0, 20, 0, -1, -1, 0);
        load(2, 4, 0, -1, -1, 0);
        seg(0, 20, 1, 1); seg(2, 4, 3, 1);
        drain(200);
        do_reset();
        load(2, 12, 0, -1, -1, 0);
        load(0, 3, 0, -1, -1, 3);
        seg(2, 8, 1, 1); seg(0, 3, 2, 1); seg(2, 4, 3, 1);
        drain(200);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
